// File: rtl/assert_collector_pkg.sv
// Shared types and helpers for the assertion event collector.
// Optional timestamping in the top level is enabled with ASSERT_COLLECTOR_TS_EN.
package assert_collector_pkg;

    localparam int LANE_W_MAX = 5;
    localparam int TS_W_MAX   = 32;

    // Widest event record; instances use the low LANE_W / TS_W bits of each field.
    typedef struct packed {
        logic [LANE_W_MAX-1:0] lane;
        logic [TS_W_MAX-1:0]   tstamp;
    } ev_t;

    function automatic int lane_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[31:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered first-word-fall-through FIFO with synchronous flush.
// dout reads as zero while empty so the consumer never sees stale entries.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/assert_event_collector.sv
// Turns per-lane checker failure pulses into an ordered, lowest-lane-first event stream.
// Define ASSERT_COLLECTOR_TS_EN to carry a free-running timestamp with each event.
module assert_event_collector
    import assert_collector_pkg::*;
#(
    parameter int LANES = 10,
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES-1:0]          fail_i,
    input  logic                      clear_i,
    output logic                      ev_valid_o,
    input  logic                      ev_ready_i,
    output logic [lane_w(LANES)-1:0]  ev_lane_o,
    output logic [TS_W-1:0]           ev_time_o,
    output logic [LANES-1:0]          sticky_o,
    output logic [CNT_W-1:0]          fail_cnt_o,
    output logic [CNT_W-1:0]          drop_cnt_o
);

    localparam int          LW      = lane_w(LANES);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [LANES-1:0] pend;
    logic [LANES-1:0] grant;
    logic [LANES-1:0] push_mask;
    logic [LANES-1:0] accept;
    logic [LANES-1:0] drop;
    logic [LW-1:0]    gnt_idx;
    logic             gnt_any;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push;
    logic [31:0]      n_acc;
    logic [31:0]      n_drop;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (pend[i]) begin
                gnt_any = 1'b1;
                gnt_idx = LW'(i);
            end
        end
        grant = gnt_any ? (LANES'(1) << gnt_idx) : '0;
    end

    assign ev_valid_o = ~fifo_empty;
    assign pop        = ev_valid_o & ev_ready_i;
    assign push       = gnt_any & (~fifo_full | pop) & ~clear_i;
    assign push_mask  = push ? grant : '0;

    // A lane being pushed this cycle is free again, so a new failure on it is accepted.
    assign accept = fail_i & (~pend | push_mask);
    assign drop   = fail_i & pend & ~push_mask;

    always_comb begin
        n_acc  = '0;
        n_drop = '0;
        for (int k = 0; k < LANES; k++) begin
            n_acc  = n_acc + 32'(accept[k]);
            n_drop = n_drop + 32'(drop[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            pend       <= '0;
            sticky_o   <= '0;
            fail_cnt_o <= '0;
            drop_cnt_o <= '0;
        end else begin
            pend       <= (pend & ~push_mask) | fail_i;
            sticky_o   <= sticky_o | fail_i;
            fail_cnt_o <= CNT_W'(sat_add(32'(fail_cnt_o), n_acc, CNT_MAX));
            drop_cnt_o <= CNT_W'(sat_add(32'(drop_cnt_o), n_drop, CNT_MAX));
        end
    end

`ifdef ASSERT_COLLECTOR_TS_EN
    localparam int FW = LW + TS_W;

    logic [TS_W-1:0]             ts;
    logic [LANES-1:0][TS_W-1:0]  ts_lane;
    logic [FW-1:0]               fifo_din;
    logic [FW-1:0]               fifo_dout;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            ts      <= '0;
            ts_lane <= '0;
        end else begin
            ts <= ts + 1'b1;
            for (int k = 0; k < LANES; k++) begin
                if (accept[k]) ts_lane[k] <= ts;
            end
        end
    end

    assign fifo_din  = {gnt_idx, ts_lane[gnt_idx]};
    assign ev_lane_o = fifo_dout[FW-1:TS_W];
    assign ev_time_o = fifo_dout[TS_W-1:0];
`else
    localparam int FW = LW;

    logic [FW-1:0] fifo_din;
    logic [FW-1:0] fifo_dout;

    assign fifo_din  = gnt_idx;
    assign ev_lane_o = fifo_dout;
    assign ev_time_o = '0;
`endif

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clear_i),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_assert_event_collector.sv
// Scoreboard bench for assert_event_collector: queue-based reference model, negedge monitor.
// Expected timestamps follow ASSERT_COLLECTOR_TS_EN when it is defined.
module tb_assert_event_collector;
    import assert_collector_pkg::*;

    localparam int LANES   = 10;
    localparam int DEPTH   = 8;
    localparam int TS_W    = 4;
    localparam int CNT_W   = 4;
    localparam int LW      = lane_w(LANES);
    localparam int TS_MOD  = 1 << TS_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ASSERT_COLLECTOR_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [LANES-1:0] fail_i;
    logic             clear_i;
    logic             ev_valid_o;
    logic             ev_ready_i;
    logic [LW-1:0]    ev_lane_o;
    logic [TS_W-1:0]  ev_time_o;
    logic [LANES-1:0] sticky_o;
    logic [CNT_W-1:0] fail_cnt_o;
    logic [CNT_W-1:0] drop_cnt_o;

    always #5 clk = ~clk;

    assert_event_collector #(
        .LANES (LANES), .DEPTH (DEPTH), .TS_W (TS_W), .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fail_i     (fail_i),
        .clear_i    (clear_i),
        .ev_valid_o (ev_valid_o),
        .ev_ready_i (ev_ready_i),
        .ev_lane_o  (ev_lane_o),
        .ev_time_o  (ev_time_o),
        .sticky_o   (sticky_o),
        .fail_cnt_o (fail_cnt_o),
        .drop_cnt_o (drop_cnt_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int   m_ts;
    bit   m_pend   [LANES];
    int   m_lts    [LANES];
    bit   m_sticky [LANES];
    int   m_fcnt;
    int   m_dcnt;
    bit   m_fresh;
    ev_t  m_fifo [$];
    ev_t  exp_q  [$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (rst || clear_i) begin
            m_ts = 0; m_fcnt = 0; m_dcnt = 0; m_fresh = 1'b1;
            for (int k = 0; k < LANES; k++) begin
                m_pend[k] = 1'b0; m_lts[k] = 0; m_sticky[k] = 1'b0;
            end
            m_fifo.delete();
            exp_q.delete();
        end else begin
            bit  pop, pushed;
            int  j;
            ev_t e;
            m_fresh = 1'b0;
            pop = (m_fifo.size() > 0) && ev_ready_i;
            j = -1;
            for (int k = 0; k < LANES; k++) if (m_pend[k] && j < 0) j = k;
            pushed = (j >= 0) && ((m_fifo.size() < DEPTH) || pop);
            e = '0;
            if (pushed) begin
                e.lane   = LANE_W_MAX'(j);
                e.tstamp = TS_EN ? 32'(m_lts[j]) : 32'd0;
                m_pend[j] = 1'b0;
            end
            for (int k = 0; k < LANES; k++) begin
                if (fail_i[k]) begin
                    m_sticky[k] = 1'b1;
                    if (!m_pend[k]) begin
                        m_pend[k] = 1'b1;
                        m_lts[k]  = m_ts;
                        m_fcnt    = (m_fcnt < CNT_MAX) ? m_fcnt + 1 : CNT_MAX;
                    end else begin
                        m_dcnt    = (m_dcnt < CNT_MAX) ? m_dcnt + 1 : CNT_MAX;
                    end
                end
            end
            if (pop) void'(m_fifo.pop_front());
            if (pushed) begin
                m_fifo.push_back(e);
                exp_q.push_back(e);
            end
            m_ts = (m_ts + 1) % TS_MOD;
        end
    end

    initial forever begin
        logic [LANES-1:0] sv;
        ev_t e;
        @(negedge clk);
        for (int k = 0; k < LANES; k++) sv[k] = m_sticky[k];
        check("ev_valid", int'(ev_valid_o), int'(m_fifo.size() > 0));
        check("sticky", int'(sticky_o), int'(sv));
        check("fail_cnt", int'(fail_cnt_o), m_fcnt);
        check("drop_cnt", int'(drop_cnt_o), m_dcnt);
        if (m_fresh) begin
            check("lane_after_reset", int'(ev_lane_o), 0);
            check("time_after_reset", int'(ev_time_o), 0);
        end
        if (ev_valid_o && ev_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_event: got lane %0d, expected no event", ev_lane_o);
            end else begin
                e = exp_q.pop_front();
                check("ev_lane", int'(ev_lane_o), int'(e.lane));
                check("ev_time", int'(ev_time_o), int'(e.tstamp));
            end
        end
    end

    task automatic drive(input logic [LANES-1:0] f, input logic c, input logic r);
        fail_i = f; clear_i = c; ev_ready_i = r;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic r);
        repeat (n) drive('0, 1'b0, r);
    endtask

    initial begin
        int guard;
        rst = 1'b1; fail_i = '0; clear_i = 1'b0; ev_ready_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;

        // Single failure on lane 3 at ts = 5
        drive('0, 1'b1, 1'b1);
        idle(5, 1'b1);
        drive(10'h008, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Burst on all lanes
        drive(10'h3FF, 1'b0, 1'b1);
        idle(14, 1'b1);

        // Backpressure: fill FIFO, leave 8 and 9 pending, re-fail lane 9
        drive('0, 1'b1, 1'b0);
        for (int i = 0; i < LANES; i++) drive(LANES'(1) << i, 1'b0, 1'b0);
        drive(10'h200, 1'b0, 1'b0);
        idle(4, 1'b0);
        idle(14, 1'b1);

        // Counter saturation
        drive('0, 1'b1, 1'b1);
        repeat (20) begin
            drive(LANES'(1) << ($urandom % LANES), 1'b0, 1'b1);
            idle(2, 1'b1);
        end
        idle(4, 1'b1);

        // Clear wins over a same-cycle failure
        drive('0, 1'b1, 1'b0);
        drive(10'h001, 1'b0, 1'b0);
        drive(10'h002, 1'b0, 1'b0);
        drive(10'h010, 1'b0, 1'b0);
        idle(3, 1'b0);
        drive(10'h004, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Reset with events queued and lanes pending
        for (int i = 0; i < LANES; i++) drive(LANES'(1) << i, 1'b0, 1'b0);
        rst = 1'b1;
        drive('0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(3, 1'b1);

        // Timestamp wrap: failures at ts = 15 and then ts = 0
        drive('0, 1'b1, 1'b1);
        guard = 0;
        while (m_ts != TS_MOD - 1 && guard < 40) begin
            idle(1, 1'b1);
            guard++;
        end
        check("wrap_reached", m_ts, TS_MOD - 1);
        drive(10'h002, 1'b0, 1'b1);
        drive(10'h004, 1'b0, 1'b1);
        idle(5, 1'b1);

        // Randomized traffic
        repeat (800) begin
            logic [LANES-1:0] f;
            f = (($urandom % 3) == 0) ? LANES'($urandom & $urandom) : '0;
            drive(f, (($urandom % 150) == 0), (($urandom % 3) != 0));
        end

        idle(40, 1'b1);
        check("drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
